// File: rtl/mult_add_acc_pipe.sv
// Pipelined unsigned multiply-add / multiply-accumulate with first/last framing,
// optional product register stages and a sticky accumulator carry-out flag.
module mult_add_acc_pipe #(
  parameter  int WIDTH     = 18,
  parameter  int PIPE      = 0,
  parameter  int GUARD     = 8,
  localparam int ACC_WIDTH = 2*WIDTH + GUARD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 sclr,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic                 first,
  input  logic                 last,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] p,
  output logic                 acc_ovf
);

  typedef struct packed {
    logic                 valid;
    logic                 mode;
    logic                 first;
    logic                 last;
    logic [WIDTH-1:0]     c;
    logic [2*WIDTH-1:0]   prod;
  } beat_t;

  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             valid_q, mode_q, first_q, last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (sclr) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (ce) begin
      a_q     <= a;
      b_q     <= b;
      c_q     <= c;
      valid_q <= in_valid;
      mode_q  <= mode;
      first_q <= first;
      last_q  <= last;
    end
  end

  beat_t stage0;
  beat_t head;

  always_comb begin
    stage0       = '0;
    stage0.valid = valid_q;
    stage0.mode  = mode_q;
    stage0.first = first_q;
    stage0.last  = last_q;
    stage0.c     = c_q;
    stage0.prod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  // With PIPE=0 the product feeds the OUT stage combinationally from the IN registers.
  if (PIPE == 0) begin : g_no_pipe
    always_comb head = stage0;
  end else begin : g_pipe
    beat_t pipe_q [PIPE];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < PIPE; i++) pipe_q[i] <= '0;
      end else if (sclr) begin
        for (int unsigned i = 0; i < PIPE; i++) pipe_q[i] <= '0;
      end else if (ce) begin
        pipe_q[0] <= stage0;
        for (int unsigned i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    always_comb head = pipe_q[PIPE-1];
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [2*WIDTH-1:0]   madd;
  logic [ACC_WIDTH:0]   madd_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_next;

  always_comb begin
    madd     = head.prod + {{WIDTH{1'b0}}, head.c};
    madd_ext = {{(GUARD+1){1'b0}}, madd};
    sum      = (head.first ? '0 : {1'b0, acc}) + madd_ext;
    ovf_next = (head.first ? 1'b0 : acc_ovf) | sum[ACC_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      acc_ovf   <= 1'b0;
    end else if (sclr) begin
      acc       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      acc_ovf   <= 1'b0;
    end else if (ce) begin
      out_valid <= 1'b0;
      if (head.valid) begin
        if (!head.mode) begin
          p         <= madd_ext[ACC_WIDTH-1:0];
          out_valid <= 1'b1;
        end else begin
          acc     <= sum[ACC_WIDTH-1:0];
          acc_ovf <= ovf_next;
          if (head.last) begin
            p         <= sum[ACC_WIDTH-1:0];
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_add_acc_pipe.sv
// Self-checking bench for mult_add_acc_pipe: directed scenarios plus randomized
// traffic compared against a queue-based arithmetic reference model.
module tb_mult_add_acc_pipe;
  localparam int WIDTH     = 8;
  localparam int PIPE      = 1;
  localparam int GUARD     = 1;
  localparam int ACC_WIDTH = 2*WIDTH + GUARD;
  localparam int LAT       = PIPE + 1;   // ce-edges from sampling edge to result edge
  localparam longint unsigned MASK = (64'd1 << ACC_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst, ce, sclr, in_valid, mode, first, last;
  logic [WIDTH-1:0]     a, b, c;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] p;
  logic                 acc_ovf;

  always #5 clk = ~clk;

  mult_add_acc_pipe #(.WIDTH(WIDTH), .PIPE(PIPE), .GUARD(GUARD)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr), .in_valid(in_valid),
    .mode(mode), .first(first), .last(last), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .p(p), .acc_ovf(acc_ovf)
  );

  typedef struct {
    int              due;
    bit              has_out;
    bit              is_acc;
    longint unsigned val;
    bit              ovf;
  } rec_t;

  rec_t            pend[$];
  int              edge_n;
  longint unsigned m_acc;
  bit              m_ovf;
  longint unsigned exp_p;
  bit              exp_ov, exp_ovf;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
  endtask

  task automatic model_clear();
    pend.delete();
    m_acc   = 0;
    m_ovf   = 0;
    exp_p   = 0;
    exp_ov  = 0;
    exp_ovf = 0;
  endtask

  task automatic model_edge();
    rec_t            r;
    longint unsigned t, s;
    if (rst || sclr) begin
      model_clear();
    end else if (ce) begin
      edge_n++;
      exp_ov = 0;
      while (pend.size() > 0 && pend[0].due == edge_n) begin
        r = pend.pop_front();
        if (r.is_acc) exp_ovf = r.ovf;
        if (r.has_out) begin
          exp_ov = 1;
          exp_p  = r.val;
        end
      end
      if (in_valid) begin
        t = 64'(a) * 64'(b) + 64'(c);
        if (!mode) begin
          pend.push_back('{edge_n + LAT, 1'b1, 1'b0, t, 1'b0});
        end else begin
          s     = (first ? 64'd0 : m_acc) + t;
          m_ovf = (first ? 1'b0 : m_ovf) | ((s >> ACC_WIDTH) != 0);
          m_acc = s & MASK;
          pend.push_back('{edge_n + LAT, last, 1'b1, m_acc, m_ovf});
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out_valid", out_valid, exp_ov);
    check("p", p, exp_p);
    check("acc_ovf", acc_ovf, exp_ovf);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic beat(input bit m, input bit f, input bit l,
                      input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
    in_valid = 1'b1; mode = m; first = f; last = l; a = x; b = y; c = z;
    cycle();
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; mode = 1'b0;
    first = 1'b0; last = 1'b0; a = '0; b = '0; c = '0;
    edge_n = 0;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_p", p, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_acc_ovf", acc_ovf, 0);
    rst = 1'b0;
    idle(2);

    // Mode 0 basic and all-ones
    beat(0, 0, 0, 8'd3, 8'd5, 8'd7);
    idle(LAT);
    check("madd_basic_p", p, 22);
    check("madd_basic_valid", out_valid, 1);
    idle(1);
    check("madd_single_pulse", out_valid, 0);
    beat(0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    idle(LAT);
    check("madd_ones_p", p, 65280);
    check("madd_ones_ovf", acc_ovf, 0);

    // Four-beat frame, then a single-term frame straight after
    beat(1, 1, 0, 8'd1, 8'd10, 8'd1);
    beat(1, 0, 0, 8'd2, 8'd10, 8'd1);
    beat(1, 0, 0, 8'd3, 8'd10, 8'd1);
    beat(1, 0, 1, 8'd4, 8'd10, 8'd1);
    beat(1, 1, 1, 8'd2, 8'd3, 8'd4);
    idle(LAT - 1);
    check("frame_sum_p", p, 104);
    idle(1);
    check("frame_restart_p", p, 10);

    // Overflow frame, then first clears the sticky flag
    beat(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
    beat(1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    beat(1, 0, 1, 8'hFF, 8'hFF, 8'hFF);
    idle(LAT);
    check("ovf_wrap_p", p, 64768);
    check("ovf_flag", acc_ovf, 1);
    beat(1, 1, 1, 8'd1, 8'd1, 8'd0);
    idle(LAT);
    check("ovf_clear_p", p, 1);
    check("ovf_cleared", acc_ovf, 0);

    // Mode 0 beat inside an open frame
    beat(1, 1, 0, 8'd5, 8'd6, 8'd1);
    beat(0, 0, 0, 8'd2, 8'd2, 8'd0);
    beat(1, 0, 0, 8'd7, 8'd1, 8'd0);
    beat(1, 0, 1, 8'd1, 8'd1, 8'd1);
    idle(LAT);
    check("interleave_frame_p", p, 40);

    // ce toggling during a mode 0 stream
    for (int i = 0, n = 0; i < 12; i++) begin
      ce = (i % 2) == 0;
      in_valid = ce && (n < 3);
      mode = 1'b0;
      a = 8'(10 + n); b = 8'(3 + n); c = 8'(n);
      if (in_valid) n++;
      cycle();
    end
    ce = 1'b1; in_valid = 1'b0;
    idle(LAT + 1);

    // Asynchronous reset mid-frame with beats in flight
    beat(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
    beat(1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    rst = 1'b1;
    #1;
    model_clear();
    check("async_rst_p", p, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ovf", acc_ovf, 0);
    cycle();
    rst = 1'b0;
    idle(LAT + 2);

    // Synchronous clear with ce low
    beat(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
    beat(1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    beat(1, 0, 1, 8'hFF, 8'hFF, 8'hFF);
    beat(0, 0, 0, 8'd4, 8'd4, 8'd4);
    ce = 1'b0; sclr = 1'b1;
    cycle();
    check("sclr_p", p, 0);
    check("sclr_ovf", acc_ovf, 0);
    sclr = 1'b0; ce = 1'b1;
    idle(LAT + 2);
    beat(1, 0, 1, 8'd2, 8'd3, 8'd0);
    idle(LAT);
    check("post_clear_acc_p", p, 6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ce       = ($urandom % 8) != 0;
      sclr     = ($urandom % 200) == 0;
      in_valid = ($urandom % 4) != 0;
      mode     = $urandom % 2;
      first    = ($urandom % 4) == 0;
      last     = ($urandom % 3) == 0;
      a = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      b = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      c = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      cycle();
    end
    ce = 1'b1; sclr = 1'b0; in_valid = 1'b0;
    idle(LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
